// File: rtl/backtrack_sequencer.sv
// backtrack_sequencer: passes joystick frames to the servos and runs a timed
// reverse/turn/cooldown recovery manoeuvre whenever a debounced bumper is hit.
module backtrack_sequencer #(
    parameter int         TICK_DIV    = 100000,
    parameter int         DEBOUNCE_MS = 20,
    parameter int         REVERSE_MS  = 2000,
    parameter int         TURN_MS     = 1500,
    parameter int         COOLDOWN_MS = 500,
    parameter logic [7:0] REV_SPEED   = 8'd64,
    parameter logic [7:0] STEER_L     = 8'd0,
    parameter logic [7:0] STEER_R     = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x_bumper,
    input  logic       y_bumper,
    input  logic [7:0] joy_x,
    input  logic [7:0] joy_y,
    input  logic       joy_valid,
    output logic [7:0] steer_pos,
    output logic [7:0] drive_pos,
    output logic       cmd_valid,
    output logic       backtrack_active,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {MANUAL, REVERSE, TURN, COOLDOWN} state_t;

    localparam int MAX_MS = (REVERSE_MS > TURN_MS) ?
                            ((REVERSE_MS > COOLDOWN_MS) ? REVERSE_MS : COOLDOWN_MS) :
                            ((TURN_MS > COOLDOWN_MS) ? TURN_MS : COOLDOWN_MS);
    localparam int PW = $clog2(MAX_MS + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [7:0]    CENTER   = 8'd128;
    localparam logic [PW-1:0] REV_END  = PW'(REVERSE_MS - 1);
    localparam logic [PW-1:0] TURN_END = PW'(TURN_MS - 1);
    localparam logic [PW-1:0] COOL_END = PW'(COOLDOWN_MS - 1);

    logic [TW-1:0]         pre;
    logic                  tick;
    logic [1:0]            s1, s2, deb;
    logic [1:0][DW-1:0]    cnt;
    logic                  deb_q, hit, done;
    state_t                state;
    logic [PW-1:0]         phase, phase_end;
    logic [7:0]            dir;

    assign tick      = pre == TW'(TICK_DIV - 1);
    assign hit       = (|deb) & ~deb_q;
    assign phase_end = state == REVERSE ? REV_END : state == TURN ? TURN_END : COOL_END;
    assign done      = tick && phase == phase_end;
    assign state_o   = state;

    // bit 0 carries x_bumper, bit 1 carries y_bumper through sync and debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            cnt   <= '0;
            deb_q <= 1'b0;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            s1    <= {y_bumper, x_bumper};
            s2    <= s1;
            deb_q <= |deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i])
                    cnt[i] <= '0;
                else if (tick) begin
                    cnt[i] <= cnt[i] == DW'(DEBOUNCE_MS - 1) ? '0 : cnt[i] + 1'b1;
                    if (cnt[i] == DW'(DEBOUNCE_MS - 1))
                        deb[i] <= ~deb[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= MANUAL;
            phase            <= '0;
            dir              <= STEER_L;
            steer_pos        <= CENTER;
            drive_pos        <= CENTER;
            cmd_valid        <= 1'b0;
            backtrack_active <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (hit && state != COOLDOWN) begin
                // re-hit in REVERSE restarts timing but leaves outputs unchanged
                state            <= REVERSE;
                phase            <= '0;
                dir              <= (deb[1] && !deb[0]) ? STEER_R : STEER_L;
                steer_pos        <= CENTER;
                drive_pos        <= REV_SPEED;
                cmd_valid        <= state != REVERSE;
                backtrack_active <= 1'b1;
            end else if (state == MANUAL) begin
                if (joy_valid) begin
                    steer_pos <= joy_x;
                    drive_pos <= joy_y;
                    cmd_valid <= 1'b1;
                end
            end else if (done) begin
                phase            <= '0;
                state            <= state == REVERSE ? TURN : state == TURN ? COOLDOWN : MANUAL;
                steer_pos        <= state == REVERSE ? dir : CENTER;
                drive_pos        <= state == REVERSE ? REV_SPEED : CENTER;
                cmd_valid        <= state != COOLDOWN;
                backtrack_active <= state != COOLDOWN;
            end else if (tick) begin
                phase <= phase + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_backtrack_sequencer.sv
// tb_backtrack_sequencer: directed vectors and hand-written recovery sequences
// for backtrack_sequencer with a 10-cycle tick and short phase lengths.
module tb_backtrack_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       x_bumper, y_bumper;
    logic [7:0] joy_x, joy_y;
    logic       joy_valid;
    logic [7:0] steer_pos, drive_pos;
    logic       cmd_valid, backtrack_active;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int st_cnt = 0;

    typedef struct {
        logic       jv;
        logic [7:0] jx, jy, es, ed;
        logic       ec;
    } vec_t;
    vec_t tv[6];

    backtrack_sequencer #(
        .TICK_DIV(10), .DEBOUNCE_MS(2), .REVERSE_MS(5), .TURN_MS(4), .COOLDOWN_MS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x_bumper(x_bumper), .y_bumper(y_bumper),
        .joy_x(joy_x), .joy_y(joy_y), .joy_valid(joy_valid),
        .steer_pos(steer_pos), .drive_pos(drive_pos), .cmd_valid(cmd_valid),
        .backtrack_active(backtrack_active), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // waits (bounded) for state s, checks entry outputs, then checks the strobe drops
    task automatic enter(input logic [1:0] s, input int lo, input int hi,
                         input logic [7:0] es, input logic [7:0] ed, input logic ev, input string nm);
        int n = 0;
        while (state_o != s && n < hi + 5) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " state"}, state_o, s);
        if (lo > 0) chk_rng({nm, " duration"}, n, lo, hi);
        chk({nm, " steer"}, steer_pos, es);
        chk({nm, " drive"}, drive_pos, ed);
        chk({nm, " cmd_valid"}, cmd_valid, ev);
        chk({nm, " active"}, backtrack_active, s != 2'd0);
        @(negedge clk);
        chk({nm, " cmd_valid drop"}, cmd_valid, 0);
    endtask

    task automatic full_seq(input logic use_x, input logic [7:0] turn_steer, input string nm);
        if (use_x) x_bumper = 1'b1; else y_bumper = 1'b1;
        enter(2'd1, 0, 40, 8'd128, 8'd64, 1'b1, {nm, " reverse"});
        x_bumper = 1'b0;
        y_bumper = 1'b0;
        enter(2'd2, 40, 49, turn_steer, 8'd64, 1'b1, {nm, " turn"});
        enter(2'd3, 30, 39, 8'd128, 8'd128, 1'b1, {nm, " cooldown"});
        enter(2'd0, 20, 29, 8'd128, 8'd128, 1'b0, {nm, " manual"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, 8'h20, 8'hE0, 8'h20, 8'hE0, 1'b1};
        tv[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};
        tv[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1};
        tv[3] = '{1'b1, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 1'b1};
        tv[4] = '{1'b0, 8'h12, 8'h34, 8'h5A, 8'hA5, 1'b0};
        tv[5] = '{1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1};
        rst_n = 1'b0;
        x_bumper = 1'b0;
        y_bumper = 1'b0;
        joy_x = 8'h00;
        joy_y = 8'h00;
        joy_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset steer", steer_pos, 128);
        chk("reset drive", drive_pos, 128);
        chk("reset cmd_valid", cmd_valid, 0);
        chk("reset active", backtrack_active, 0);
        chk("reset state", state_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            joy_valid = tv[i].jv;
            joy_x = tv[i].jx;
            joy_y = tv[i].jy;
            @(negedge clk);
            joy_valid = 1'b0;
            chk($sformatf("vec%0d steer", i), steer_pos, tv[i].es);
            chk($sformatf("vec%0d drive", i), drive_pos, tv[i].ed);
            chk($sformatf("vec%0d cmd_valid", i), cmd_valid, tv[i].ec);
            chk($sformatf("vec%0d state", i), state_o, 0);
            @(negedge clk);
            chk($sformatf("vec%0d cmd_valid drop", i), cmd_valid, 0);
        end

        full_seq(1'b0, 8'd255, "s2");

        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 33; c++) begin
                x_bumper = c < 8;
                @(negedge clk);
                cv_cnt += int'(cmd_valid);
                st_cnt += int'(state_o != 2'd0);
            end
        x_bumper = 1'b0;
        chk("s3 glitch cmd_valid count", cv_cnt, 0);
        chk("s3 glitch state changes", st_cnt, 0);

        y_bumper = 1'b1;
        enter(2'd1, 0, 40, 8'd128, 8'd64, 1'b1, "s4 reverse");
        y_bumper = 1'b0;
        enter(2'd2, 40, 49, 8'd255, 8'd64, 1'b1, "s4 turn");
        x_bumper = 1'b1;
        enter(2'd1, 0, 35, 8'd128, 8'd64, 1'b1, "s4 rehit");
        x_bumper = 1'b0;
        enter(2'd2, 40, 49, 8'd0, 8'd64, 1'b1, "s4 turn left");
        enter(2'd3, 30, 39, 8'd128, 8'd128, 1'b1, "s4 cooldown");
        enter(2'd0, 20, 29, 8'd128, 8'd128, 1'b0, "s4 manual");

        joy_x = 8'h11;
        joy_y = 8'h22;
        joy_valid = 1'b1;
        y_bumper = 1'b1;
        enter(2'd1, 0, 40, 8'd128, 8'd64, 1'b1, "s5 hit priority");
        joy_valid = 1'b0;
        y_bumper = 1'b0;
        enter(2'd2, 40, 49, 8'd255, 8'd64, 1'b1, "s5 turn");
        enter(2'd3, 30, 39, 8'd128, 8'd128, 1'b1, "s5 cooldown");
        joy_x = 8'h33;
        joy_y = 8'h44;
        joy_valid = 1'b1;
        @(negedge clk);
        joy_valid = 1'b0;
        chk("s5 cooldown joy steer", steer_pos, 128);
        chk("s5 cooldown joy drive", drive_pos, 128);
        chk("s5 cooldown joy cmd_valid", cmd_valid, 0);
        enter(2'd0, 0, 35, 8'd128, 8'd128, 1'b0, "s5 manual");
        repeat (5) @(negedge clk);
        chk("s5 hold steer", steer_pos, 128);
        chk("s5 hold drive", drive_pos, 128);
        joy_x = 8'h55;
        joy_y = 8'h66;
        joy_valid = 1'b1;
        @(negedge clk);
        joy_valid = 1'b0;
        chk("s5 fresh steer", steer_pos, 8'h55);
        chk("s5 fresh drive", drive_pos, 8'h66);
        chk("s5 fresh cmd_valid", cmd_valid, 1);

        y_bumper = 1'b1;
        enter(2'd1, 0, 40, 8'd128, 8'd64, 1'b1, "s6 reverse");
        y_bumper = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s6 async steer", steer_pos, 128);
        chk("s6 async drive", drive_pos, 128);
        chk("s6 async state", state_o, 0);
        chk("s6 async active", backtrack_active, 0);
        chk("s6 async cmd_valid", cmd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6 release state", state_o, 0);
        chk("s6 release cmd_valid", cmd_valid, 0);
        chk("s6 release steer", steer_pos, 128);
        full_seq(1'b1, 8'd0, "s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
